// File: rtl/ssd_pkg.sv
// Shared types, defaults and the hex-to-segment decode table for the display scanner.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package ssd_pkg;

  localparam int N_DIGITS_DEFAULT = 8;

  // All segments dark (active-low gfedcba)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Phase of a digit slot: anodes forced off, then PWM-gated on
  typedef enum logic {
    SLOT_DEAD = 1'b0,
    SLOT_ON   = 1'b1
  } slot_state_t;

  // Hex nibble to active-low gfedcba segment pattern
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Decodes one hex nibble into the active-low gfedcba segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/ssd_scan_scheduler.sv
// Scans an N-digit seven-segment display with per-slot dead-time and 16-step PWM brightness.
// Latency: pins are registered one cycle after the slot/digit counter state; load_ack one cycle after frame end.
// Backpressure: load_req is held until load_ack; capture happens only at the frame boundary (max one frame wait).
module ssd_scan_scheduler
  import ssd_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEFAULT,
  parameter int DIGIT_TICKS = 100000,
  parameter int DEAD_TICKS  = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  load_req,
  output logic                  load_ack,
  input  logic [3:0]            brightness,
  output logic [N_DIGITS-1:0]   AN,
  output logic [7:0]            CA,
  output logic                  frame_start
);

  localparam int SW = $clog2(DIGIT_TICKS);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_TICKS - 1);
  localparam logic [SW-1:0] DEAD_LAST  = SW'(DEAD_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  // PWM phase only needs the low nibble: (slot_cnt - DEAD_TICKS) mod 16
  localparam logic [3:0]    DEAD_PHASE = 4'(DEAD_TICKS % 16);

  // The ON window must hold at least one full PWM period
  if (DIGIT_TICKS < DEAD_TICKS + 16) begin : g_param_check
    $error("ssd_scan_scheduler: DIGIT_TICKS must be >= DEAD_TICKS+16");
  end

  logic [SW-1:0]   slot_cnt;
  logic [IW-1:0]   idx;
  slot_state_t     state;
  logic [3:0]      bright_q;

  logic [3:0]      dig_sh [N_DIGITS];
  logic [N_DIGITS-1:0] dp_sh;
  logic [N_DIGITS-1:0] blank_sh;

  logic            slot_end;
  logic            frame_end;
  logic [3:0]      pwm;
  logic [3:0]      cur_nib;
  logic [6:0]      cur_seg;
  logic            lit;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign pwm       = slot_cnt[3:0] - DEAD_PHASE;
  assign cur_nib   = dig_sh[idx];
  // Digit is driven only outside dead-time and when not blanked
  assign lit       = (state == SLOT_ON) && !blank_sh[idx];

  ssd_hex_decoder u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // Slot/digit counters, DEAD/ON slot FSM, brightness latch and registered pin drive
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      slot_cnt    <= '0;
      idx         <= '0;
      state       <= SLOT_DEAD;
      bright_q    <= '0;
      AN          <= '1;
      CA          <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      case (state)
        SLOT_DEAD: begin
          // Brightness is sampled once per slot so the duty never changes mid-slot
          if (slot_cnt == DEAD_LAST) begin
            state    <= SLOT_ON;
            bright_q <= brightness;
          end
        end
        SLOT_ON: begin
          if (slot_end) state <= SLOT_DEAD;
        end
        default: state <= SLOT_DEAD;
      endcase

      AN <= '1;
      if (lit && (pwm < bright_q)) AN[idx] <= 1'b0;

      CA          <= lit ? {~dp_sh[idx], cur_seg} : {1'b1, SEG_BLANK};
      frame_start <= (slot_cnt == '0) && (idx == '0);
    end
  end

  // Shadow display content, replaced only at the frame boundary when requested
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N_DIGITS; i++) dig_sh[i] <= '0;
      dp_sh    <= '0;
      blank_sh <= '1;
      load_ack <= 1'b0;
    end else begin
      load_ack <= frame_end && load_req;
      if (frame_end && load_req) begin
        for (int i = 0; i < N_DIGITS; i++) dig_sh[i] <= digits_in[4*i +: 4];
        dp_sh    <= dp_in;
        blank_sh <= blank_in;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Self-checking bench: randomized loads/brightness against a cycle-count based display model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ssd_scan_scheduler;

  localparam int ND    = 8;
  localparam int DT    = 32;
  localparam int DD    = 4;
  localparam int FRAME = ND * DT;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        load_req = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic        load_ack;
  logic [7:0]  AN;
  logic [7:0]  CA;
  logic        frame_start;

  ssd_scan_scheduler #(
    .N_DIGITS    (ND),
    .DIGIT_TICKS (DT),
    .DEAD_TICKS  (DD)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .load_req    (load_req),
    .load_ack    (load_ack),
    .brightness  (brightness),
    .AN          (AN),
    .CA          (CA),
    .frame_start (frame_start)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] ca;
    logic       fs;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  // Number of clocks since reset release == current DUT counter position
  int   mc = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [31:0] m_dig;
  logic [7:0]  m_dp;
  logic [7:0]  m_blank;
  int          m_bright;

  // Reference model: derives digit/slot from elapsed clocks and predicts next-cycle pins
  initial begin : model
    exp_t e;
    int slot, dig, pwm;
    logic [3:0] nib;
    forever begin
      @(posedge CLK);
      if (!RST) begin
        mc = 0; m_dig = '0; m_dp = '0; m_blank = 8'hFF; m_bright = 0;
        e = '{an: 8'hFF, ca: 8'hFF, fs: 1'b0, ack: 1'b0};
      end else begin
        slot  = mc % DT;
        dig   = (mc / DT) % ND;
        e.an  = 8'hFF;
        e.ca  = 8'hFF;
        e.fs  = (slot == 0) && (dig == 0);
        e.ack = (slot == DT-1) && (dig == ND-1) && load_req;
        if (slot >= DD && !m_blank[dig]) begin
          pwm = (slot - DD) % 16;
          if (pwm < m_bright) e.an[dig] = 1'b0;
          nib  = m_dig[dig*4 +: 4];
          e.ca = {~m_dp[dig], seg_tbl[nib]};
        end
        if (e.ack) begin
          m_dig = digits_in; m_dp = dp_in; m_blank = blank_in;
        end
        if (slot == DD-1) m_bright = int'(brightness);
        mc++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expectation per cycle and compares pins away from the clock edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (AN !== e.an || CA !== e.ca || frame_start !== e.fs || load_ack !== e.ack) begin
          errors++;
          $display("FAIL pins @%0t: got AN=%h CA=%h fs=%b ack=%b, want AN=%h CA=%h fs=%b ack=%b",
                   $time, AN, CA, frame_start, load_ack, e.an, e.ca, e.fs, e.ack);
        end
      end
    end
  end

  task automatic wait_phase(input int modulus, input int value);
    int k;
    k = 0;
    while ((mc % modulus) != value && k < 2*FRAME) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 2*FRAME) begin
      checks++; errors++;
      $display("FAIL wait_phase: timeout got phase %0d, want %0d", mc % modulus, value);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                         input logic aligned, output int n);
    if (!aligned) @(negedge CLK);
    digits_in = d; dp_in = dp; blank_in = bl; load_req = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (load_ack !== 1'b1 && n < FRAME + 50);
    load_req = 1'b0;
    checks++;
    if (n < 1 || n > FRAME) begin
      errors++;
      $display("FAIL ack_latency: got %0d cycles, want 1..%0d", n, FRAME);
    end
  endtask

  initial begin : stim
    int n;
    logic [31:0] d;
    logic [7:0]  dp, bl;

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;

    // First frame after reset is dark
    repeat (FRAME + 10) @(negedge CLK);

    // Basic load, full brightness, dp on digit 0
    brightness = 4'hF;
    do_load(32'h76543210, 8'h01, 8'h00, 1'b0, n);
    repeat (FRAME + 5) @(negedge CLK);

    // Request raised in slot 3: old digits persist until the frame boundary
    wait_phase(FRAME, 3*DT + 5);
    do_load(32'hFEDCBA98, 8'h80, 8'h00, 1'b1, n);
    checks++;
    if (n != FRAME - (3*DT + 5)) begin
      errors++;
      $display("FAIL midframe_latency: got %0d, want %0d", n, FRAME - (3*DT + 5));
    end
    repeat (FRAME) @(negedge CLK);

    // PWM levels, then a mid-slot brightness change
    brightness = 4'd4;
    repeat (FRAME) @(negedge CLK);
    brightness = 4'd0;
    repeat (FRAME) @(negedge CLK);
    wait_phase(DT, 10);
    brightness = 4'd9;
    repeat (FRAME) @(negedge CLK);

    // Odd digits blanked
    do_load(32'h13579BDF, 8'h55, 8'hAA, 1'b0, n);
    repeat (FRAME + 5) @(negedge CLK);

    // Request present exactly in the frame_end cycle
    wait_phase(FRAME, FRAME - 1);
    do_load(32'h2468ACE0, 8'hF0, 8'h00, 1'b1, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL exact_frame_end: got ack after %0d cycles, want 1", n);
    end

    // Request held past ack is recaptured every frame
    @(negedge CLK);
    digits_in = 32'hC0FFEE11; dp_in = 8'h3C; blank_in = 8'h81; load_req = 1'b1;
    repeat (2*FRAME + 20) @(negedge CLK);
    load_req = 1'b0;

    // Randomized loads and brightness changes
    for (int i = 0; i < 8; i++) begin
      d  = $urandom;
      dp = 8'($urandom_range(0, 255));
      bl = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
      brightness = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 300)) @(negedge CLK);
      do_load(d, dp, bl, 1'b0, n);
      repeat ($urandom_range(0, 100)) @(negedge CLK);
      brightness = 4'($urandom_range(0, 15));
      repeat ($urandom_range(20, 200)) @(negedge CLK);
    end

    // Reset mid-slot during a pending request: pins dark immediately, request dropped
    wait_phase(DT, DD + 6);
    digits_in = 32'h11111111; dp_in = 8'hFF; blank_in = 8'h00; load_req = 1'b1;
    repeat (7) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (AN !== 8'hFF || CA !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: got AN=%h CA=%h, want AN=ff CA=ff", AN, CA);
    end
    load_req = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    repeat (FRAME + 10) @(negedge CLK);

    // Recovery after reset
    brightness = 4'd12;
    do_load(32'h89ABCDEF, 8'h0F, 8'h00, 1'b0, n);
    repeat (FRAME + 5) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
